// File: rtl/sl_bus_arbiter.sv
// Round-robin arbiter for the shared ICE slave output bus; one client holds the grant per frame.
// Optional idle-latch grant timeout with per-client masking: define SL_ARB_TIMEOUT_EN.
module sl_bus_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] req,
   input  logic               sl_data_latch,
   output logic [NUM_REQ-1:0] grant,
   output logic               grant_valid,
   output logic [2:0]         grant_idx,
   output logic [7:0]         byte_count,
   output logic               frame_done,
   output logic               timeout_evt
);

   localparam int unsigned IDX_W = 3;
   localparam int unsigned CNT_W = 8;
   localparam int unsigned EXT_W = 8;
   localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_GAP
   } state_t;

   state_t             state;
   state_t             state_d;
   logic [NUM_REQ-1:0] grant_d;
   logic [IDX_W-1:0]   grant_idx_d;
   logic [CNT_W-1:0]   byte_count_d;
   logic               frame_done_d;
   logic               timeout_d;
   logic [IDX_W-1:0]   last_idx;
   logic [IDX_W-1:0]   last_idx_d;

   logic [NUM_REQ-1:0] eligible;
   logic [EXT_W-1:0]   eligible_ext;
   logic [EXT_W-1:0]   req_ext;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   win_idx;
   logic               win_found;
   logic               tmo_hit;

   assign req_ext      = EXT_W'(req);
   assign eligible_ext = EXT_W'(eligible);

`ifdef SL_ARB_TIMEOUT_EN
   logic [15:0]        idle_cnt;
   logic [15:0]        idle_cnt_d;
   logic [NUM_REQ-1:0] mask;
   logic [NUM_REQ-1:0] mask_d;

   assign eligible = req & ~mask;
   assign tmo_hit  = (idle_cnt == (TIMEOUT_CYCLES - 16'd1));

   // Idle counter runs only while granted; a mask bit lives until its req is seen low.
   always_comb begin
      idle_cnt_d = '0;
      if (state == S_GRANT && !sl_data_latch) begin
         idle_cnt_d = idle_cnt + 16'd1;
      end
      mask_d = (mask & req) | (timeout_d ? grant : '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt <= '0;
         mask     <= '0;
      end else begin
         idle_cnt <= idle_cnt_d;
         mask     <= mask_d;
      end
   end
`else
   logic unused_tmo;

   assign eligible   = req;
   assign tmo_hit    = 1'b0;
   assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

   // Round-robin search starting one past the last grantee.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((32'(last_idx) + i) % NUM_REQ);
         if (!win_found && eligible_ext[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state;
      grant_d      = grant;
      grant_idx_d  = grant_idx;
      byte_count_d = byte_count;
      last_idx_d   = last_idx;
      frame_done_d = 1'b0;
      timeout_d    = 1'b0;
      case (state)
         S_IDLE: begin
            if (win_found) begin
               grant_d      = NUM_REQ'(1) << win_idx;
               grant_idx_d  = win_idx;
               byte_count_d = '0;
               state_d      = S_GRANT;
            end
         end
         S_GRANT: begin
            if (sl_data_latch && byte_count != '1) begin
               byte_count_d = byte_count + 8'd1;
            end
            if (!req_ext[grant_idx]) begin
               grant_d      = '0;
               frame_done_d = 1'b1;
               last_idx_d   = grant_idx;
               state_d      = S_GAP;
            end else if (tmo_hit) begin
               grant_d    = '0;
               timeout_d  = 1'b1;
               last_idx_d = grant_idx;
               state_d    = S_GAP;
            end
         end
         S_GAP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         byte_count  <= '0;
         frame_done  <= 1'b0;
         timeout_evt <= 1'b0;
         last_idx    <= LAST_RST;
      end else begin
         state       <= state_d;
         grant       <= grant_d;
         grant_valid <= |grant_d;
         grant_idx   <= grant_idx_d;
         byte_count  <= byte_count_d;
         frame_done  <= frame_done_d;
         timeout_evt <= timeout_d;
         last_idx    <= last_idx_d;
      end
   end

endmodule

// File: tb/tb_sl_bus_arbiter.sv
// Directed bench for sl_bus_arbiter: a scoreboard of expected grantees and frame byte counts.
module tb_sl_bus_arbiter;

   localparam int unsigned NUM_REQ = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_REQ-1:0] req;
   logic               sl_data_latch;
   logic [NUM_REQ-1:0] grant;
   logic               grant_valid;
   logic [2:0]         grant_idx;
   logic [7:0]         byte_count;
   logic               frame_done;
   logic               timeout_evt;

   int compared   = 0;
   int mismatched = 0;

   int unsigned exp_grant_q[$];
   int unsigned exp_bytes_q[$];
   int unsigned e_val;
   logic        gv_prev = 1'b0;

   sl_bus_arbiter #(
      .NUM_REQ       (NUM_REQ),
      .TIMEOUT_CYCLES(16'd20)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .sl_data_latch(sl_data_latch),
      .grant        (grant),
      .grant_valid  (grant_valid),
      .grant_idx    (grant_idx),
      .byte_count   (byte_count),
      .frame_done   (frame_done),
      .timeout_evt  (timeout_evt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Scoreboard: pop expected grantee on each new grant, expected byte count on each frame_done.
   always @(negedge clk) begin
      if (!rst) begin
         chk("grant_valid_or", 32'(grant_valid), 32'(|grant));
         chk("grant_onehot", 32'($onehot0(grant)), 1);
         chk("done_and_tmo", 32'(frame_done & timeout_evt), 0);
         if (grant_valid && !gv_prev) begin
            if (exp_grant_q.size() == 0) begin
               chk("grant_unexpected", 32'(grant), 0);
            end else begin
               e_val = exp_grant_q.pop_front();
               chk("sb_grant_idx", 32'(grant_idx), e_val);
               chk("sb_grant_vec", 32'(grant), 32'(1) << e_val);
            end
         end
         if (frame_done) begin
            if (exp_bytes_q.size() == 0) begin
               chk("done_unexpected", 32'(frame_done), 0);
            end else begin
               e_val = exp_bytes_q.pop_front();
               chk("sb_frame_bytes", 32'(byte_count), e_val);
            end
         end
      end
      gv_prev = grant_valid;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst           = 1'b1;
      req           = '0;
      sl_data_latch = 1'b0;
      tick(3);
      chk("rst_grant", 32'(grant), 0);
      chk("rst_grant_valid", 32'(grant_valid), 0);
      chk("rst_grant_idx", 32'(grant_idx), 0);
      chk("rst_byte_count", 32'(byte_count), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_timeout_evt", 32'(timeout_evt), 0);

      // Two pending clients after reset: client 1 wins, one-cycle latency.
      rst = 1'b0;
      req = 4'b0110;
      exp_grant_q.push_back(1);
      tick();
      chk("s1_grant", 32'(grant), 32'h2);
      chk("s1_grant_idx", 32'(grant_idx), 1);
      chk("s1_bytes_start", 32'(byte_count), 0);
      sl_data_latch = 1'b1;
      tick(5);
      sl_data_latch = 1'b0;
      chk("s1_bytes_run", 32'(byte_count), 5);
      req = 4'b0100;
      exp_bytes_q.push_back(5);
      exp_grant_q.push_back(2);
      tick();
      chk("s1_release_grant", 32'(grant), 0);
      chk("s1_release_done", 32'(frame_done), 1);
      chk("s1_release_bytes", 32'(byte_count), 5);
      tick();
      chk("s1_gap_grant", 32'(grant), 0);
      chk("s1_gap_done", 32'(frame_done), 0);
      tick();
      chk("s1_next_grant", 32'(grant), 32'h4);
      chk("s1_next_idx", 32'(grant_idx), 2);
      chk("s1_next_bytes", 32'(byte_count), 0);

      // Latches outside a grant are ignored.
      req = '0;
      exp_bytes_q.push_back(0);
      tick();
      chk("s2_release_done", 32'(frame_done), 1);
      sl_data_latch = 1'b1;
      tick(4);
      sl_data_latch = 1'b0;
      chk("s2_idle_bytes", 32'(byte_count), 0);
      chk("s2_idle_grant", 32'(grant_valid), 0);

      // All clients pending, each releases after one byte: rotation 0,1,2,3,0,1.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b1111;
      exp_grant_q.push_back(0);
      tick();
      chk("rr_first", 32'(grant), 32'h1);
      for (int k = 0; k < 5; k++) begin
         sl_data_latch = 1'b1;
         tick();
         sl_data_latch = 1'b0;
         req[2'(k % 4)] = 1'b0;
         exp_bytes_q.push_back(1);
         exp_grant_q.push_back(32'((k + 1) % 4));
         tick();
         chk("rr_release_done", 32'(frame_done), 1);
         chk("rr_release_grant", 32'(grant), 0);
         req[2'(k % 4)] = 1'b1;
         tick();
         chk("rr_gap_grant", 32'(grant), 0);
         tick();
         chk("rr_next_grant", 32'(grant), 32'(1) << ((k + 1) % 4));
      end

      // Saturation at 255 on client 1's grant.
      sl_data_latch = 1'b1;
      tick(254);
      chk("sat_254", 32'(byte_count), 254);
      tick();
      chk("sat_255", 32'(byte_count), 255);
      tick(45);
      chk("sat_hold", 32'(byte_count), 255);
      chk("sat_grant", 32'(grant), 32'h2);
      sl_data_latch = 1'b0;

      // Reset mid-grant drops the grant; lowest pending index wins afterwards.
      rst = 1'b1;
      req = 4'b1010;
      tick();
      chk("mid_rst_grant", 32'(grant), 0);
      chk("mid_rst_valid", 32'(grant_valid), 0);
      chk("mid_rst_bytes", 32'(byte_count), 0);
      rst = 1'b0;
      exp_grant_q.push_back(1);
      tick();
      chk("post_rst_grant", 32'(grant), 32'h2);
      req = '0;
      exp_bytes_q.push_back(0);
      tick();
      chk("post_rst_done", 32'(frame_done), 1);
      tick(2);

`ifdef SL_ARB_TIMEOUT_EN
      // Client 2 never latches: revoked at grant cycle 20, masked until req drops.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0100;
      exp_grant_q.push_back(2);
      tick();
      chk("tmo_grant", 32'(grant), 32'h4);
      req = 4'b1100;
      exp_grant_q.push_back(3);
      tick(19);
      chk("tmo_hold_grant", 32'(grant), 32'h4);
      chk("tmo_hold_evt", 32'(timeout_evt), 0);
      tick();
      chk("tmo_evt", 32'(timeout_evt), 1);
      chk("tmo_evt_grant", 32'(grant), 0);
      chk("tmo_evt_done", 32'(frame_done), 0);
      tick(2);
      chk("tmo_next_grant", 32'(grant), 32'h8);
      chk("tmo_evt_cleared", 32'(timeout_evt), 0);
      req = 4'b0100;
      exp_bytes_q.push_back(0);
      tick();
      chk("tmo_c3_done", 32'(frame_done), 1);
      tick(6);
      chk("tmo_masked", 32'(grant_valid), 0);
      req = '0;
      tick();
      req = 4'b0100;
      exp_grant_q.push_back(2);
      tick();
      chk("tmo_unmasked", 32'(grant), 32'h4);
      req = '0;
      exp_bytes_q.push_back(0);
      tick(3);
`endif

      chk("sb_grant_empty", 32'(exp_grant_q.size()), 0);
      chk("sb_bytes_empty", 32'(exp_bytes_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/sl_bus_arbiter.md
# sl_bus_arbiter

Round-robin arbiter for the shared ICE slave output bus. Each bus client (basics block, GOC/I2C/MBus bridges, …) raises a frame request when its output message FIFO holds a complete frame. The arbiter grants exactly one client at a time and holds the grant for the whole frame. The granted client alone drives `sl_data`/`sl_overflow` and consumes `sl_data_latch`. The block sits between the clients' `sl_arb_request`/`sl_arb_grant` pins and the host-side frame consumer.

## Interface
- `NUM_REQ`, 4: number of requesting clients (2–8).
- `TIMEOUT_CYCLES`, 16'd50000: idle-latch limit for a granted frame; used only with the timeout macro.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  NUM_REQ  per-client `sl_arb_request`; high while the client's frame is pending or in transfer.
- `sl_data_latch`  in  1  consumer strobe; one byte is taken from the granted client per high cycle.
- `grant`  out  NUM_REQ  one-hot `sl_arb_grant` vector, registered.
- `grant_valid`  out  1  OR of `grant`.
- `grant_idx`  out  3  index of the current or last grantee.
- `byte_count`  out  8  number of latches in the current or last frame, saturating at 255.
- `frame_done`  out  1  one-cycle pulse when a grant ends normally.
- `timeout_evt`  out  1  one-cycle pulse when a grant is revoked by timeout. Tied to 0 without the macro.

## Operation
- The state machine has three states: IDLE, GRANT, GAP.
- **IDLE**: if any unmasked `req` bit is high, select the winner by round-robin. The search starts at `last_idx+1` mod NUM_REQ. Then:
  - set `grant[winner]`;
  - set `grant_idx` to the winner;
  - clear `byte_count`;
  - go to GRANT.
- **GRANT**: `grant` is held constant.
  - Each cycle with `sl_data_latch` high increments `byte_count`, saturating at 255.
  - When `req[grant_idx]` is low: clear `grant`, pulse `frame_done`, set `last_idx = grant_idx`, go to GAP.
- **GAP**: exactly one cycle with no grant (tristate turnaround). Then go to IDLE.
- `sl_data_latch` outside GRANT is ignored and does not change `byte_count`.
- Reset values:
  - state IDLE;
  - `grant` = 0, `grant_valid` = 0;
  - `grant_idx` = 0, `byte_count` = 0;
  - `frame_done` = 0, `timeout_evt` = 0;
  - `last_idx` = NUM_REQ-1, so client 0 has first priority;
  - mask = 0.
- Reset during GRANT drops `grant` on the same edge.
- Request bits for indices ≥ NUM_REQ do not exist. `grant_idx` is zero-extended to 3 bits.

## Timing
- Grant latency: `req` rising in IDLE gives `grant` high on the next edge, one cycle.
- Release latency: `req[grant_idx]` falling gives `grant` low and `frame_done` high on the next edge. Grantee bytes may still latch in that cycle and are counted.
- Back-to-back frames: a minimum of 3 cycles from one grant's end to the next grant start (release edge, GAP, IDLE decision).
- Simultaneous requests: resolved purely by the round-robin pointer, with no fixed priority after the first grant.
- If the grantee drops and re-raises `req` inside GAP, it competes normally in IDLE. Round-robin still gives other pending clients precedence.
- `frame_done` and `timeout_evt` are never high in the same cycle.

## Configuration
- `SL_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter runs in GRANT. It clears on each `sl_data_latch` and on grant start, and increments otherwise.
  - When it reaches TIMEOUT_CYCLES-1 with `req` still high:
    - clear `grant`;
    - pulse `timeout_evt` (no `frame_done`);
    - set the mask bit for that client;
    - go to GAP.
  - A masked client is excluded from arbitration until its `req` is observed low, which clears the mask bit.
- `SL_ARB_TIMEOUT_EN` undefined:
  - no counter and no mask;
  - a grant lasts until `req` drops, indefinitely;
  - `timeout_evt` is constant 0.

## Test plan
- After reset, raise `req`=4'b0110 → `grant`=4'b0010 one cycle later, `grant_idx`=1.
- Client 1 gets 5 latches, then drops `req` → `frame_done` pulse, `byte_count`=5, GAP cycle with `grant`=0, then `grant`=4'b0100.
- Hold `req`=4'b1111 with each client releasing after 1 byte → grant order 0,1,2,3,0, with 3-cycle spacing between grants.
- Hold 300 latches in one grant → `byte_count` saturates at 255 and never wraps.
- Assert `rst` mid-GRANT → next edge `grant`=0, `byte_count`=0. The first grant after release goes to the lowest pending index.
- With `SL_ARB_TIMEOUT_EN` and TIMEOUT_CYCLES=20, client 2 is granted and never latches → `timeout_evt` at cycle 20 of the grant. Client 3 (pending) is granted next. Client 2 is not re-granted until its `req` toggles low.
